// File: rtl/frame_pixel_packer.sv
// Packs a serial R,G,B byte stream into 24-bit pixels, buffers them in a small FIFO
// and plays them out against programmable display timing (DE/HSync/VSync).
module frame_pixel_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CSDisplay,
  input  logic [7:0]  FrameIn,
  input  logic        FrameValid,
  output logic        FrameReady,
  input  logic [9:0]  AIPOut,
  input  logic [9:0]  HBOut,
  input  logic [9:0]  AILOut,
  input  logic [9:0]  VBOut,
  output logic [23:0] PixOut,
  output logic        DE,
  output logic        HSync,
  output logic        VSync,
  output logic        Underrun,
  output logic        FrameDone
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_R = 2'd0;
  localparam logic [1:0] S_G = 2'd1;
  localparam logic [1:0] S_B = 2'd2;

  // ---------------- byte assembler ----------------
  logic [1:0]  state_reg;
  logic [7:0]  r_reg;
  logic [7:0]  g_reg;
  logic        ready_en_reg;

  // ---------------- pixel FIFO ----------------
  logic [23:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          byte_acc;
  logic          push;
  logic          pop;

  // ---------------- display timing ----------------
  logic [10:0] px_reg;
  logic [10:0] ln_reg;
  logic [9:0]  aip_sh_reg;
  logic [9:0]  hb_sh_reg;
  logic [9:0]  ail_sh_reg;
  logic [9:0]  vb_sh_reg;
  logic        frame_start;
  logic [9:0]  cfg_aip;
  logic [9:0]  cfg_hb;
  logic [9:0]  cfg_ail;
  logic [9:0]  cfg_vb;
  logic [10:0] h_sum;
  logic [10:0] v_sum;
  logic [10:0] h_total;
  logic [10:0] v_total;
  logic        h_last;
  logic        v_last;
  logic        active;

  logic [23:0] pix_reg;
  logic        de_reg;
  logic        hsync_reg;
  logic        vsync_reg;
  logic        underrun_reg;
  logic        frame_done_reg;

  assign fifo_full  = (count_reg == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);

  // Only the byte that would complete a pixel can be refused; R and G bytes just land in registers.
  assign FrameReady = ready_en_reg && !((state_reg == S_B) && fifo_full);
  assign byte_acc   = FrameValid && FrameReady;
  assign push       = byte_acc && (state_reg == S_B);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_R;
      r_reg        <= '0;
      g_reg        <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (byte_acc) begin
        case (state_reg)
          S_R:     begin r_reg <= FrameIn; state_reg <= S_G; end
          S_G:     begin g_reg <= FrameIn; state_reg <= S_B; end
          default: state_reg <= S_R;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {r_reg, g_reg, FrameIn};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // At the frame origin the live inputs apply directly, so a new geometry takes
  // effect on pixel (0,0) itself rather than one cycle late.
  assign frame_start = (px_reg == '0) && (ln_reg == '0);
  assign cfg_aip = frame_start ? AIPOut : aip_sh_reg;
  assign cfg_hb  = frame_start ? HBOut  : hb_sh_reg;
  assign cfg_ail = frame_start ? AILOut : ail_sh_reg;
  assign cfg_vb  = frame_start ? VBOut  : vb_sh_reg;

  assign h_sum   = {1'b0, cfg_aip} + {1'b0, cfg_hb};
  assign v_sum   = {1'b0, cfg_ail} + {1'b0, cfg_vb};
  assign h_total = (h_sum == '0) ? 11'd1 : h_sum;
  assign v_total = (v_sum == '0) ? 11'd1 : v_sum;
  assign h_last  = (px_reg == h_total - 11'd1);
  assign v_last  = (ln_reg == v_total - 11'd1);

  assign active = CSDisplay && (px_reg < {1'b0, cfg_aip}) && (ln_reg < {1'b0, cfg_ail});
  assign pop    = active && !fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_reg     <= '0;
      ln_reg     <= '0;
      aip_sh_reg <= '0;
      hb_sh_reg  <= '0;
      ail_sh_reg <= '0;
      vb_sh_reg  <= '0;
    end else begin
      if (frame_start) begin
        aip_sh_reg <= AIPOut;
        hb_sh_reg  <= HBOut;
        ail_sh_reg <= AILOut;
        vb_sh_reg  <= VBOut;
      end
      if (!CSDisplay) begin
        px_reg <= '0;
        ln_reg <= '0;
      end else if (h_last) begin
        px_reg <= '0;
        ln_reg <= v_last ? 11'd0 : ln_reg + 11'd1;
      end else begin
        px_reg <= px_reg + 11'd1;
      end
    end
  end

  // Outputs describe the counter position of the previous cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_reg        <= '0;
      de_reg         <= 1'b0;
      hsync_reg      <= 1'b0;
      vsync_reg      <= 1'b0;
      underrun_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else if (!CSDisplay) begin
      pix_reg        <= '0;
      de_reg         <= 1'b0;
      hsync_reg      <= 1'b0;
      vsync_reg      <= 1'b0;
      underrun_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      pix_reg        <= pop ? mem[rd_ptr_reg] : 24'd0;
      de_reg         <= active;
      hsync_reg      <= (px_reg >= {1'b0, cfg_aip});
      vsync_reg      <= (ln_reg >= {1'b0, cfg_ail});
      frame_done_reg <= h_last && v_last;
      if (active && fifo_empty) underrun_reg <= 1'b1;
    end
  end

  assign PixOut    = pix_reg;
  assign DE        = de_reg;
  assign HSync     = hsync_reg;
  assign VSync     = vsync_reg;
  assign Underrun  = underrun_reg;
  assign FrameDone = frame_done_reg;

endmodule
